// File: rtl/pipe_adder_n.sv
// Pipelined WIDTH-bit add/subtract with a valid/ready stream interface.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder_n #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int C = WIDTH / STAGES;

  function automatic logic [C:0] chunk_add(input logic [C-1:0] a, input logic [C-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + {{C{1'b0}}, c};
  endfunction

  // The whole pipe moves as one; a held output freezes every stage behind it.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * C;
    localparam int DW = (k + 1) * C;

    logic [RW-1:0] a_i;
    logic [RW-1:0] b_i;
    logic          c_i;
    logic          v_i;
    logic [C:0]    r;
    logic [DW-1:0] s_nx;
    logic [DW-1:0] s_q;
    logic          c_q;
    logic          v_q;

    // Stage k boundary: chunk k is added; upper operand chunks skew, lower results deskew.
    if (k == 0) begin : g_in
      assign a_i  = ain;
      assign b_i  = sub ? ~bin : bin;
      assign c_i  = cin ^ sub;
      assign v_i  = in_valid;
      assign s_nx = r[C-1:0];
    end else begin : g_mid
      assign a_i  = g_st[k-1].g_sk.a_q;
      assign b_i  = g_st[k-1].g_sk.b_q;
      assign c_i  = g_st[k-1].c_q;
      assign v_i  = g_st[k-1].v_q;
      assign s_nx = {r[C-1:0], g_st[k-1].s_q};
    end

    assign r = chunk_add(a_i[C-1:0], b_i[C-1:0], c_i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= r[C];
        s_q <= s_nx;
      end
    end

    if (k < STAGES - 1) begin : g_sk
      logic [RW-C-1:0] a_q;
      logic [RW-C-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i[RW-1:C];
          b_q <= b_i[RW-1:C];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= r[C] ^ (a_i[C-1] ^ b_i[C-1] ^ r[C-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sout      = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: doc/pipe_adder_n.md
Name: pipe_adder_n

Overview:
- Parametrised, pipelined successor to the combinational 4-bit ripple-carry adder. Adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES equal chunks, with one pipeline register per chunk.
- Sits on datapaths that need high Fmax and a valid/ready stream interface instead of a purely combinational adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (chunks); 1 <= STAGES <= WIDTH; latency = STAGES cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- ain  input  WIDTH  operand A.
- bin  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode) / borrow-in (sub mode).
- sub  input  1  0 = add, 1 = subtract; sampled with the operands.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts a result.
- sout  output  WIDTH  result.
- cout  output  1  add: carry-out; sub: 1 = no borrow, 0 = borrow.

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline registers. out_valid=0, sout=0, cout=0, all internal valid bits = 0. Reset asserted mid-stream drops every in-flight beat; after release the pipe is empty.
- Arithmetic:
  - add: {cout,sout} = ain + bin + cin.
  - sub: {cout,sout} = ain + ~bin + ~cin (i.e. ain - bin - cin); cout=1 means no borrow.
  - Wrap-around is modulo 2^WIDTH.
- Chunking: chunk width C = WIDTH/STAGES.
  - Stage k (k = 0..STAGES-1) adds chunk k of A and B (B pre-inverted in sub mode) plus the registered carry from stage k-1. Stage 0 uses cin, or ~cin in sub mode.
  - Unprocessed upper chunks travel as skew registers; completed lower result chunks travel as deskew registers. A beat's chunks therefore stay aligned.
- Valid tracking: each stage carries a valid bit.
- Global stall: advance = out_ready | ~out_valid.
  - When advance=1, every stage shifts one place and stage 0 captures the input beat with valid = in_valid.
  - When advance=0, all stages hold, including data and valid bits.
  - in_ready = advance (combinational from out_ready and out_valid).
- Transfers: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
- Bubbles are not collapsed: an invalid stage still shifts and occupies its slot.
- Latency: a beat accepted at edge N appears on sout/cout with out_valid=1 after edge N+STAGES-1 (STAGES registers). Zero-bubble throughput of 1 beat/cycle when out_ready is held high.
- Output stability: while out_valid=1 and out_ready=0, sout, cout and out_valid hold constant.
- Simultaneous out_ready rising with in_valid: the output beat transfers and the new input beat is accepted in the same cycle.
- STAGES=1: single register after a full-width add; latency 1.
- Not ready for input: in_valid with in_ready=0 does not accept; the source must hold the beat (standard valid/ready).
- No combinational path from ain/bin/cin/sub to any output.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered and aligned with sout. ovf = signed two's-complement overflow of the final operation: carry into MSB XOR carry out of MSB of the effective addition.
  - ovf resets to 0 and holds during stall like sout.
- When not defined: the port and its logic are absent; everything else is identical.

Test Plan:
- Add wrap: WIDTH=16, STAGES=4, sub=0, ain=0xFFFF, bin=0x0001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, sout=0x0000, cout=1.
- Cross-chunk carry: ain=0x00FF, bin=0x0001, cin=1 -> sout=0x0101, cout=0 (carry ripples through stage 1 registers).
- Subtract with borrow: sub=1, ain=0x0005, bin=0x0007, cin=0 -> sout=0xFFFE, cout=0; then ain=0x0007, bin=0x0005, cin=1 -> sout=0x0001, cout=1.
- Streaming + backpressure: 8 back-to-back random beats, out_ready low for cycles 6-8 -> in_ready=0 during the stall, outputs held stable, all 8 results emerge in order, none lost or duplicated, matched against a reference model.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 and sout=0 immediately (asynchronous); after release, only beats accepted after reset appear.
- PIPE_ADDER_OVF_EN: ain=0x7FFF, bin=0x0001, sub=0 -> ovf=1; ain=0x8000, bin=0x0001, sub=1 -> ovf=1; ain=0x0001, bin=0x0001 -> ovf=0.
